shared_counters_host: RTL

SHARED_COUNTERS_HOST -- requirements
Module: shared_counters_host

---
 rtl/shared_counters_pkg.sv | 42 ++++
 rtl/read_assembler.sv | 45 ++++
 rtl/shared_counters_host.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/shared_counters_pkg.sv
// Shared counter host: command encodings, request opcodes and FSM states.
package shared_counters_pkg;

  localparam logic [2:0] CMD_IDLE    = 3'b000;
  localparam logic [2:0] CMD_INCR    = 3'b001;
  localparam logic [2:0] CMD_NEW     = 3'b010;
  localparam logic [2:0] CMD_DEALLOC = 3'b011;
  localparam logic [2:0] CMD_LOAD    = 3'b100;
  localparam logic [2:0] CMD_READ    = 3'b101;

  typedef enum logic [2:0] {
    OP_INCR    = 3'd0,
    OP_ALLOC   = 3'd1,
    OP_DEALLOC = 3'd2,
    OP_LOAD    = 3'd3,
    OP_READ    = 3'd4
  } req_op_e;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_ISSUE      = 3'd1,
    ST_WAIT_READ  = 3'd2,
    ST_WAIT_ALLOC = 3'd3,
    ST_RESP       = 3'd4
  } state_e;

  // Map a request opcode onto the counter-bank command bus; unknown ops issue nothing.
  function automatic logic [2:0] op_to_cmd(input logic [2:0] op);
    logic [2:0] cmd;
    cmd = CMD_IDLE;
    case (op)
      OP_INCR:    cmd = CMD_INCR;
      OP_ALLOC:   cmd = CMD_NEW;
      OP_DEALLOC: cmd = CMD_DEALLOC;
      OP_LOAD:    cmd = CMD_LOAD;
      OP_READ:    cmd = CMD_READ;
      default:    cmd = CMD_IDLE;
    endcase
    return cmd;
  endfunction

endpackage

// File: rtl/read_assembler.sv
// Collects G-bit read chunks LSB-first into a W-bit word; flags the final chunk and overflow.
module read_assembler #(
  parameter int unsigned G = 4,
  parameter int unsigned W = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         en,
  input  logic         valid,
  input  logic         last,
  input  logic [G-1:0] rdata,
  output logic [W-1:0] data_c,
  output logic         done_c,
  output logic         ovf_c
);
  localparam int unsigned NCHUNK = W / G;
  localparam int unsigned KW     = $clog2(NCHUNK + 1);

  logic [KW-1:0] k_q;
  logic [W-1:0]  data_q;
  logic          full_c;
  logic          take_c;

  // A chunk arriving once every slot is filled is never stored.
  assign full_c = (k_q == KW'(NCHUNK));
  assign take_c = en && valid && !full_c;
  assign done_c = en && valid && last;
  assign ovf_c  = en && valid && full_c && !last;
  assign data_c = take_c ? (data_q | (W'(rdata) << (G * k_q))) : data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_q    <= '0;
      data_q <= '0;
    end else if (clear) begin
      k_q    <= '0;
      data_q <= '0;
    end else begin
      data_q <= data_c;
      if (take_c) k_q <= k_q + KW'(1);
    end
  end

endmodule

// File: rtl/shared_counters_host.sv
// Request/response front end for a shared counter bank.
// Define SHARED_COUNTERS_HOST_TIMEOUT_EN to add a watchdog on the read/alloc wait states.
module shared_counters_host
  import shared_counters_pkg::*;
#(
  parameter int unsigned N              = 10,
  parameter int unsigned G              = 4,
  parameter int unsigned W              = 64,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [2:0]           req_op,
  input  logic [$clog2(N)-1:0] req_id,
  input  logic [31:0]          req_size,
  input  logic [W-1:0]         req_data,
  output logic [2:0]           command_out,
  output logic [$clog2(N)-1:0] id_out,
  output logic [31:0]          new_counter_size_out,
  output logic [W-1:0]         load_data_out,
  output logic                 valid_load_data_out,
  input  logic [G-1:0]         rdata_in,
  input  logic                 valid_data_in,
  input  logic                 last_in,
  input  logic [$clog2(N):0]   allocation_id_in,
  input  logic                 valid_allocation_id_in,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [2:0]           rsp_op,
  output logic [W-1:0]         rsp_data,
  output logic                 rsp_err
);
  localparam int unsigned IDW = $clog2(N);

  state_e         state_q, state_d;
  logic [2:0]     op_q;
  logic [IDW-1:0] id_q;

  logic           req_ready_d;
  logic [2:0]     cmd_d;
  logic [IDW-1:0] id_d;
  logic [31:0]    size_d;
  logic [W-1:0]   load_d;
  logic           vld_load_d;
  logic           rsp_valid_d;
  logic [2:0]     rsp_op_d;
  logic [W-1:0]   rsp_data_d;
  logic           rsp_err_d;

  logic           accept_c;
  logic           in_read_c;
  logic           in_alloc_c;
  logic           rd_done_c;
  logic           rd_ovf_c;
  logic           timeout_c;
  logic [W-1:0]   rd_data_c;

  assign accept_c   = req_valid && req_ready && (state_q == ST_IDLE);
  assign in_read_c  = (state_q == ST_WAIT_READ);
  assign in_alloc_c = (state_q == ST_WAIT_ALLOC);

  read_assembler #(.G(G), .W(W)) u_read_assembler (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (state_q == ST_IDLE),
    .en     (in_read_c),
    .valid  (valid_data_in),
    .last   (last_in),
    .rdata  (rdata_in),
    .data_c (rd_data_c),
    .done_c (rd_done_c),
    .ovf_c  (rd_ovf_c)
  );

`ifdef SHARED_COUNTERS_HOST_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wd_q;
  logic          wd_kick_c;

  // Watchdog restarts on every accepted read chunk and idles outside the wait states.
  assign wd_kick_c = in_read_c && valid_data_in;
  assign timeout_c = (in_read_c || in_alloc_c) && !wd_kick_c && (wd_q == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                    wd_q <= '0;
    else if (!(in_read_c || in_alloc_c) || wd_kick_c) wd_q <= '0;
    else                                           wd_q <= wd_q + TW'(1);
  end
`else
  assign timeout_c = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q <= '0;
      id_q <= '0;
    end else if (accept_c) begin
      op_q <= req_op;
      id_q <= req_id;
    end
  end

  // Next-state and next-output logic; outputs are registered from the next state.
  always_comb begin
    state_d    = state_q;
    rsp_data_d = rsp_data;
    rsp_err_d  = rsp_err;
    case (state_q)
      ST_IDLE: if (accept_c) state_d = ST_ISSUE;
      ST_ISSUE: begin
        case (op_q)
          OP_ALLOC: state_d = ST_WAIT_ALLOC;
          OP_READ:  state_d = ST_WAIT_READ;
          default: begin
            state_d    = ST_RESP;
            rsp_data_d = '0;
            rsp_err_d  = 1'b0;
          end
        endcase
      end
      ST_WAIT_ALLOC: begin
        if (valid_allocation_id_in) begin
          state_d    = ST_RESP;
          rsp_data_d = W'(allocation_id_in);
          rsp_err_d  = 1'b0;
        end else if (timeout_c) begin
          state_d    = ST_RESP;
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
        end
      end
      ST_WAIT_READ: begin
        if (rd_done_c || rd_ovf_c || timeout_c) begin
          state_d    = ST_RESP;
          rsp_data_d = rd_data_c;
          rsp_err_d  = !rd_done_c;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d    = ST_IDLE;
          rsp_data_d = '0;
          rsp_err_d  = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    req_ready_d = (state_d == ST_IDLE);
    cmd_d       = CMD_IDLE;
    id_d        = '0;
    size_d      = '0;
    load_d      = '0;
    vld_load_d  = 1'b0;
    // ISSUE is only entered on accept, so the live request fields feed the issue registers.
    if (state_d == ST_ISSUE) begin
      cmd_d      = op_to_cmd(req_op);
      id_d       = req_id;
      size_d     = req_size;
      load_d     = req_data;
      vld_load_d = (req_op == OP_LOAD);
    end else if (state_d == ST_WAIT_READ) begin
      cmd_d = CMD_READ;
      id_d  = id_q;
    end
    rsp_valid_d = (state_d == ST_RESP);
    rsp_op_d    = (state_d == ST_RESP) ? op_q : 3'b000;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q              <= ST_IDLE;
      req_ready            <= 1'b0;
      command_out          <= CMD_IDLE;
      id_out               <= '0;
      new_counter_size_out <= '0;
      load_data_out        <= '0;
      valid_load_data_out  <= 1'b0;
      rsp_valid            <= 1'b0;
      rsp_op               <= '0;
      rsp_data             <= '0;
      rsp_err              <= 1'b0;
    end else begin
      state_q              <= state_d;
      req_ready            <= req_ready_d;
      command_out          <= cmd_d;
      id_out               <= id_d;
      new_counter_size_out <= size_d;
      load_data_out        <= load_d;
      valid_load_data_out  <= vld_load_d;
      rsp_valid            <= rsp_valid_d;
      rsp_op               <= rsp_op_d;
      rsp_data             <= rsp_data_d;
      rsp_err              <= rsp_err_d;
    end
  end

endmodule
